// File: rtl/usb_pid_pkg.sv
// -----------------------------------------------------------------------------
// usb_pid_pkg
// Shared definitions for the hub's USB handshake transmit path.
//   - Handshake PID codes (ACK, NAK, STALL, NYET)
//   - SYNC byte as it appears on the serial link
//   - State encoding of the handshake transmitter FSM
//   - pid_field(): builds the on-wire PID byte {~pid, pid}
// -----------------------------------------------------------------------------
package usb_pid_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    localparam logic [1:0] HS_ST_IDLE = 2'd0;
    localparam logic [1:0] HS_ST_SYNC = 2'd1;
    localparam logic [1:0] HS_ST_PID  = 2'd2;
    localparam logic [1:0] HS_ST_EOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = HS_ST_IDLE,
        S_SYNC = HS_ST_SYNC,
        S_PID  = HS_ST_PID,
        S_EOP  = HS_ST_EOP
    } hs_tx_state_e;

    // Upper nibble is the one's complement check field.
    function automatic logic [7:0] pid_field(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/usb_piso8.sv
// -----------------------------------------------------------------------------
// usb_piso8
// 8-bit parallel-in / serial-out register, shifting right (LSB first).
// The current serial bit is the register's bit 0, so the serial output is a
// flop. Zeros are shifted in from the top, which leaves the output at 0 once
// all eight bits have gone out.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   load_i   in   load data_i; bit 0 becomes the current bit, count clears
//   shift_i  in   advance to the next bit, count increments
//   data_i   in   8-bit parallel load value
//   bit_o    out  current serial bit
//   last_o   out  current bit is the 8th bit of the loaded byte
// -----------------------------------------------------------------------------
module usb_piso8
    import usb_pid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       bit_o,
    output logic       last_o
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = 3'd0;
        end else if (shift_i) begin
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shift_q[0];
    assign last_o = (cnt_q == 3'd7);

endmodule

// File: rtl/usb_handshake_tx.sv
// -----------------------------------------------------------------------------
// usb_handshake_tx
// Bit-serial transmitter for USB handshake packets. A send request in a cycle
// with ready high latches the PID and emits the PID byte {~pid, pid} LSB
// first as one contiguous run of valid bits, followed by a two-cycle
// end-of-packet gap whose second cycle carries the done pulse.
//
// Build option
//   USB_HS_TX_SYNC_EN  defined: every packet is preceded by the SYNC byte
//                      8'h80 (16 valid bits per packet, 19-cycle period).
//                      undefined: PID byte only (8 valid bits, 11-cycle period).
//
// Ports
//   clk                    in   clock
//   rst                    in   synchronous active-high reset
//   send                   in   transmit request, taken only while ready=1
//   pid_in[3:0]            in   PID, sampled in the accept cycle
//   ready                  out  idle, a send this cycle is accepted
//   serial_data_out        out  current serial bit
//   serial_data_out_valid  out  serial_data_out carries a packet bit
//   done                   out  one-cycle pulse in the last EOP cycle
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for send, ready=1 (except the first cycle after reset)
// SYNC  | emitting the SYNC byte (only with USB_HS_TX_SYNC_EN)
// PID   | emitting the PID byte
// EOP   | two idle-line cycles, done in the second, then back to IDLE
// -----------------------------------------------------------------------------
module usb_handshake_tx
    import usb_pid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [3:0] pid_in,
    output logic       ready,
    output logic       serial_data_out,
    output logic       serial_data_out_valid,
    output logic       done
);

    hs_tx_state_e state_q, state_d;
    logic         eop2_q, eop2_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
`ifdef USB_HS_TX_SYNC_EN
    // PID byte waits here while the shifter is busy with SYNC.
    logic [7:0]   pid_field_q, pid_field_d;
`endif

    logic       piso_load;
    logic       piso_shift;
    logic [7:0] piso_data;
    logic       piso_bit;
    logic       piso_last;

    usb_piso8 u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .data_i  (piso_data),
        .bit_o   (piso_bit),
        .last_o  (piso_last)
    );

    // Outputs are registered from the next state, so each register holds the
    // value for the cycle the shifter is presenting.
    always_comb begin
        state_d    = state_q;
        eop2_d     = 1'b0;
        ready_d    = 1'b0;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = 8'h00;
`ifdef USB_HS_TX_SYNC_EN
        pid_field_d = pid_field_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                // ready_q gates the first post-reset cycle, where IDLE is
                // already entered but ready is still low.
                if (ready_q && send) begin
                    ready_d   = 1'b0;
                    valid_d   = 1'b1;
                    piso_load = 1'b1;
`ifdef USB_HS_TX_SYNC_EN
                    piso_data   = SYNC_PATTERN;
                    pid_field_d = pid_field(pid_in);
                    state_d     = S_SYNC;
`else
                    piso_data = pid_field(pid_in);
                    state_d   = S_PID;
`endif
                end
            end
`ifdef USB_HS_TX_SYNC_EN
            S_SYNC: begin
                valid_d = 1'b1;
                if (piso_last) begin
                    // Reload straight into the PID byte: no gap in valid.
                    piso_load = 1'b1;
                    piso_data = pid_field_q;
                    state_d   = S_PID;
                end else begin
                    piso_shift = 1'b1;
                end
            end
`endif
            S_PID: begin
                // The final shift empties the register, so data reads 0 in EOP.
                piso_shift = 1'b1;
                if (piso_last) begin
                    state_d = S_EOP;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_EOP: begin
                if (!eop2_q) begin
                    eop2_d = 1'b1;
                    done_d = 1'b1;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            eop2_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef USB_HS_TX_SYNC_EN
            pid_field_q <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            eop2_q  <= eop2_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef USB_HS_TX_SYNC_EN
            pid_field_q <= pid_field_d;
`endif
        end
    end

    assign ready                 = ready_q;
    assign serial_data_out       = piso_bit;
    assign serial_data_out_valid = valid_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_usb_handshake_tx.sv
module tb_usb_handshake_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [3:0] pid_in;
    logic       ready;
    logic       serial_data_out;
    logic       serial_data_out_valid;
    logic       done;

    always #5 clk = ~clk;

`ifdef USB_HS_TX_SYNC_EN
    localparam int PLEN = 16;
    localparam logic [15:0] EXP_NAK   = 16'h5A80;
    localparam logic [15:0] EXP_ACK   = 16'hD280;
    localparam logic [15:0] EXP_STALL = 16'h1E80;
    localparam logic [15:0] EXP_NYET  = 16'h9680;
`else
    localparam int PLEN = 8;
    localparam logic [15:0] EXP_NAK   = 16'h005A;
    localparam logic [15:0] EXP_ACK   = 16'h00D2;
    localparam logic [15:0] EXP_STALL = 16'h001E;
    localparam logic [15:0] EXP_NYET  = 16'h0096;
`endif
    localparam int PERIOD = PLEN + 3;

    usb_handshake_tx dut (
        .clk                   (clk),
        .rst                   (rst),
        .send                  (send),
        .pid_in                (pid_in),
        .ready                 (ready),
        .serial_data_out       (serial_data_out),
        .serial_data_out_valid (serial_data_out_valid),
        .done                  (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packet timeline: accept at edge N puts the model at t=1; t=1..PLEN are
    // packet bits, t=PLEN+1..PLEN+2 are the EOP gap (done at PLEN+2), then idle.
    bit          m_busy  = 1'b0;
    bit          m_ready = 1'b0;
    int          m_t     = 0;
    logic [15:0] m_seq   = '0;
    int          cyc     = 0;

    function automatic logic [15:0] packet_bits(input logic [3:0] p);
        logic [7:0] f;
        f = {~p, p};
`ifdef USB_HS_TX_SYNC_EN
        return {f, 8'h80};
`else
        return {8'h00, f};
`endif
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_t     <= 0;
        end else if (!m_busy) begin
            if (m_ready && send) begin
                m_busy  <= 1'b1;
                m_ready <= 1'b0;
                m_t     <= 1;
                m_seq   <= packet_bits(pid_in);
            end else begin
                m_ready <= 1'b1;
            end
        end else if (m_t == PLEN + 2) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
            m_t     <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic ev, ed, edn;
        ev  = m_busy && (m_t <= PLEN);
        ed  = 1'b0;
        if (ev) ed = m_seq[m_t-1];
        edn = m_busy && (m_t == PLEN + 2);
        check("ready", ready, m_ready);
        check("valid", serial_data_out_valid, ev);
        check("data", serial_data_out, ed);
        check("done", done, edn);
    end

    // ---------------- stream collector ----------------
    logic [15:0] cap      = '0;
    int          cap_n    = 0;
    logic        prev_v   = 1'b0;
    logic [15:0] last_pkt = '0;
    int          last_len = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          done_gap = 0;

    always @(negedge clk) begin
        if (serial_data_out_valid === 1'b1) begin
            if (!prev_v) begin
                cap   = '0;
                cap_n = 0;
            end
            if (cap_n < 16) cap[cap_n] = serial_data_out;
            cap_n++;
        end
        if (done === 1'b1) begin
            last_pkt      = cap;
            last_len      = cap_n;
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
            done_cnt++;
        end
        prev_v = (serial_data_out_valid === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", ready, 1);
    endtask

    task automatic send_pkt(input logic [3:0] p);
        wait_ready(4 * PERIOD);
        send   = 1'b1;
        pid_in = p;
        @(negedge clk);
        send   = 1'b0;
        pid_in = 4'($urandom);
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) check("done_timeout", done_cnt, base + 1);
    endtask

    initial begin
        int base;
        int n;
        rst    = 1'b1;
        send   = 1'b1;
        pid_in = 4'hA;

        // Reset held with send high: nothing may start.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", ready, 0);
            check("rst_valid", serial_data_out_valid, 0);
            check("rst_done", done, 0);
        end
        rst  = 1'b0;
        send = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1);

        // NAK with an ignored send pulse while busy.
        base = done_cnt;
        send_pkt(4'hA);
        @(negedge clk);
        @(negedge clk);
        send   = 1'b1;
        pid_in = 4'hE;
        @(negedge clk);
        send   = 1'b0;
        wait_done(base, 4 * PERIOD);
        check("nak_bits", last_pkt, EXP_NAK);
        check("nak_len", last_len, PLEN);
        @(negedge clk);
        check("nak_ready_after_done", ready, 1);

        // ACK.
        base = done_cnt;
        send_pkt(4'h2);
        wait_done(base, 4 * PERIOD);
        check("ack_bits", last_pkt, EXP_ACK);
        check("ack_len", last_len, PLEN);

        // STALL with send held: back-to-back packets at the full rate.
        wait_ready(4 * PERIOD);
        base   = done_cnt;
        send   = 1'b1;
        pid_in = 4'hE;
        n = 0;
        while (done_cnt < base + 2 && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        send = 1'b0;
        check("stall_two_done", done_cnt, base + 2);
        check("stall_bits", last_pkt, EXP_STALL);
        check("stall_period", done_gap, PERIOD);

        // Reset at the 4th PID bit of a NAK, then a clean NYET.
        send_pkt(4'hA);
        repeat (PLEN - 8 + 3) @(negedge clk);
        check("pre_rst_valid", serial_data_out_valid, 1);
        rst  = 1'b1;
        base = done_cnt;
        @(negedge clk);
        check("midrst_valid", serial_data_out_valid, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", ready, 1);
        check("midrst_no_done", done_cnt, base);
        send_pkt(4'h6);
        wait_done(base, 4 * PERIOD);
        check("nyet_bits", last_pkt, EXP_NYET);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            send   = ($urandom_range(0, 3) == 0);
            pid_in = 4'($urandom);
            rst    = ($urandom_range(0, 79) == 0);
        end
        rst  = 1'b0;
        send = 1'b0;
        repeat (PERIOD + 3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
